register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   32-entry integer register file; responder side of the decoder's register interface.
//   Serves two combinational read ports (rs1/rs2) addressed by the instruction decoder.
//   Accepts one synchronous write per cycle from the write-back stage.
//   x0 reads as zero at all times; optional write-to-read bypass closes the same-cycle WB->ID hazard.
// PARAMETERS
//   REG_WIDTH   32  data width of each register and of all data ports
//   REG_COUNT   32  number of architectural registers; address width fixed at 5 bits
//   BYPASS      1   1: a read of the register being written this cycle returns wr_data; 0: returns stored value
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous, active-high reset
//   rs1_addr   in   5          read port 1 address (from decoder)
//   rs2_addr   in   5          read port 2 address (from decoder)
//   rs1_data   out  REG_WIDTH  read port 1 data (to decoder)
//   rs2_data   out  REG_WIDTH  read port 2 data (to decoder)
//   wr_en      in   1          write strobe from write-back stage
//   rd_addr    in   5          write address
//   wr_data    in   REG_WIDTH  write data
//   wr_count   out  16         committed-write counter (writes to x1..x31 only), debug/perf
// BEHAVIOUR
//   Reset:
//   - rst high clears all REG_COUNT entries to 0 and wr_count to 0 immediately, without waiting for clk.
//   - While rst is high, writes are ignored and rs1_data/rs2_data read 0.
//   - Deassertion is synchronised by the system; the block needs no internal reset state.
//   Reads:
//   - Purely combinational, zero latency: rsN_data follows rsN_addr in the same cycle.
//   - rsN_addr == 0 -> rsN_data = 0, regardless of BYPASS or pending write.
//   - BYPASS=1, wr_en=1, rd_addr == rsN_addr != 0 -> rsN_data = wr_data in that same cycle.
//   - BYPASS=0 -> the old value is read until the clock edge commits the write.
//   - Both ports may address the same register; both then return the same value.
//   Writes:
//   - Commit on the rising clk edge when wr_en=1 and rd_addr != 0; the new value is visible from the next cycle.
//   - wr_en=1 with rd_addr == 0: storage is unchanged, x0 stays 0, and wr_count does not increment.
//   - wr_en=0: storage and wr_count hold.
//   - Addresses >= REG_COUNT (only possible when REG_COUNT < 32):
//     - writes are dropped and not counted;
//     - reads return 0.
//   wr_count:
//   - Increments by 1 on every committed write.
//   - Wraps from 16'hFFFF to 0 with no flag.
//   Simultaneous events:
//   - Read and write to the same address in one cycle: resolved per BYPASS as above.
//   - No write-write conflict exists (single write port).
//   Reset mid-operation:
//   - rst asserted in the same cycle as a write: the reset wins, the register stays 0 and wr_count stays 0.
//   Storage:
//   - Entry 0 is never stored.
//   - The implementation must not infer a writable x0 flop; tie it to constant 0.
// TESTING
//   1. Assert rst, then release; read all 32 addresses on both ports -> every read returns 0, wr_count = 0.
//   2. Write x5=32'hDEADBEEF, next cycle read rs1=5, rs2=5 -> both 32'hDEADBEEF; wr_count = 1.
//   3. wr_en=1, rd_addr=0, wr_data=32'hFFFFFFFF; read rs1=0 -> 0 in that cycle and the next; wr_count unchanged.
//   4. BYPASS=1: x7 holds 1, write x7=32'h12345678 while reading rs2=7 -> rs2_data=32'h12345678 in the same cycle;
//      BYPASS=0: same stimulus -> 1 in the same cycle, 32'h12345678 in the next cycle.
//   5. Write x10=32'hA5A5A5A5, then pulse rst between clock edges -> x10 reads 0 before the next edge;
//      a write in the same cycle as rst -> the target stays 0.
//   6. Preload wr_count to 16'hFFFF via 65535 writes, then write x1 -> wr_count = 0; x1 holds the new value.

Source files
------------

// File: rtl/register_file.sv
// Integer register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Latency: reads are zero-cycle combinational; writes become visible the cycle after the commit edge.
// Backpressure: none; a write is accepted every cycle that wr_en is high and rst is low.
module register_file #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [REG_WIDTH-1:0] rs1_data,
  output logic [REG_WIDTH-1:0] rs2_data,
  input  logic                 wr_en,
  input  logic [4:0]           rd_addr,
  input  logic [REG_WIDTH-1:0] wr_data,
  output logic [15:0]          wr_count
);

  // Six bits so that REG_COUNT = 32 is representable for the range compare.
  localparam logic [5:0] COUNT_W = 6'(REG_COUNT);

  // Entry 0 has no storage at all; it is produced as a constant on the read side.
  logic [REG_WIDTH-1:0] regs_q [1:REG_COUNT-1];
  logic [REG_WIDTH-1:0] regs_d [1:REG_COUNT-1];
  logic [15:0]          wr_count_q;
  logic [15:0]          wr_count_d;

  logic rs1_ok;
  logic rs2_ok;
  logic wr_commit;

  // Address qualification: x0 and out-of-range addresses never hit storage.
  always_comb begin
    rs1_ok    = (rs1_addr != 5'd0) && ({1'b0, rs1_addr} < COUNT_W);
    rs2_ok    = (rs2_addr != 5'd0) && ({1'b0, rs2_addr} < COUNT_W);
    wr_commit = wr_en && (rd_addr != 5'd0) && ({1'b0, rd_addr} < COUNT_W);
  end

  // Next-state: the single write port updates at most one entry and bumps the counter.
  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (wr_commit) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (rd_addr == 5'(i)) begin
          regs_d[i] = wr_data;
        end
      end
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  // Storage and counter; reset clears everything immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      for (int i = 1; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_count_q <= wr_count_d;
    end
  end

  // Read muxes with optional write-through bypass; rst forces both ports to zero.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (rs1_addr == 5'(i)) begin
        rs1_data = regs_q[i];
      end
      if (rs2_addr == 5'(i)) begin
        rs2_data = regs_q[i];
      end
    end
    if (BYPASS && wr_en && (rd_addr == rs1_addr)) begin
      rs1_data = wr_data;
    end
    if (BYPASS && wr_en && (rd_addr == rs2_addr)) begin
      rs2_data = wr_data;
    end
    if (rst || !rs1_ok) begin
      rs1_data = '0;
    end
    if (rst || !rs2_ok) begin
      rs2_data = '0;
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: three instances (bypass, no bypass, 16 entries) share one stimulus stream.
// Expected read data and counts come from an array model and are queued per cycle.
// A negedge monitor pops the queue and compares all outputs of all instances.
module tb_register_file;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        wr_en;
  logic [31:0] wr_data;

  logic [ND-1:0][31:0] rs1_o;
  logic [ND-1:0][31:0] rs2_o;
  logic [ND-1:0][15:0] cnt_o;

  always #5 clk = ~clk;

  register_file #(.REG_WIDTH(32), .REG_COUNT(32), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_o[0]), .rs2_data(rs2_o[0]), .wr_en(wr_en), .rd_addr(rd_addr),
    .wr_data(wr_data), .wr_count(cnt_o[0]));

  register_file #(.REG_WIDTH(32), .REG_COUNT(32), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_o[1]), .rs2_data(rs2_o[1]), .wr_en(wr_en), .rd_addr(rd_addr),
    .wr_data(wr_data), .wr_count(cnt_o[1]));

  register_file #(.REG_WIDTH(32), .REG_COUNT(16), .BYPASS(1'b1)) dut_small (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_o[2]), .rs2_data(rs2_o[2]), .wr_en(wr_en), .rd_addr(rd_addr),
    .wr_data(wr_data), .wr_count(cnt_o[2]));

  // Reference model: plain arrays of architectural state, one per instance.
  int          byp [ND] = '{1, 0, 1};
  int          cnum[ND] = '{32, 32, 16};
  logic [31:0] mem [ND][32];
  logic [15:0] mcnt[ND];

  typedef struct packed {
    logic [ND-1:0][31:0] r1;
    logic [ND-1:0][31:0] r2;
    logic [ND-1:0][15:0] cnt;
  } exp_t;

  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input logic [4:0] a);
    if (rst || a == 5'd0 || int'(a) >= cnum[d]) return 32'h0;
    if (byp[d] != 0 && wr_en && rd_addr == a) return wr_data;
    return mem[d][a];
  endfunction

  task automatic model_clear();
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 32; i++) mem[d][i] = 32'h0;
      mcnt[d] = 16'h0;
    end
  endtask

  // Apply one cycle of stimulus, queue its expected outputs, then account for the commit edge.
  task automatic drive(input logic r, input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input bit pulse = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; wr_en = we; rd_addr = rd; wr_data = wd; rs1_addr = a1; rs2_addr = a2;
    if (pulse) begin
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
    end
    if (r || pulse) model_clear();
    for (int d = 0; d < ND; d++) begin
      e.r1[d]  = model_read(d, a1);
      e.r2[d]  = model_read(d, a2);
      e.cnt[d] = mcnt[d];
    end
    sbq.push_back(e);
    if (!r) begin
      for (int d = 0; d < ND; d++) begin
        if (we && rd != 5'd0 && int'(rd) < cnum[d]) begin
          mem[d][rd] = wd;
          mcnt[d]    = mcnt[d] + 16'd1;
        end
      end
    end
  endtask

  // Monitor: outputs are combinational, so each queued entry is compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("rs1_data[dut%0d] addr=%0d", d, rs1_addr), rs1_o[d], e.r1[d]);
        chk($sformatf("rs2_data[dut%0d] addr=%0d", d, rs2_addr), rs2_o[d], e.r2[d]);
        chk($sformatf("wr_count[dut%0d]", d), {16'h0, cnt_o[d]}, {16'h0, e.cnt[d]});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_addr = '0; wr_data = '0; rs1_addr = '0; rs2_addr = '0;
    model_clear();

    // Reset, then every address on both ports reads zero.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    for (int i = 0; i < 32; i++) drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

    // Plain write then read on both ports.
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

    // Write to x0 is discarded and not counted.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);

    // Same-cycle read of the register being written (bypass vs no bypass).
    drive(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

    // Asynchronous reset pulse between edges, then a write shadowed by reset.
    drive(1'b0, 1'b1, 5'd10, 32'hA5A5A5A5, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10, 1'b1);
    drive(1'b0, 1'b1, 5'd11, 32'h5555AAAA, 5'd0, 5'd0);
    drive(1'b1, 1'b1, 5'd12, 32'h77777777, 5'd12, 5'd11);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd11);

    // Out-of-range write/read for the 16-entry instance.
    drive(1'b0, 1'b1, 5'd20, 32'h0BADF00D, 5'd20, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd20);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0), 1'($urandom), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
    end

    // Run the counter to its top value, then one more write wraps it to zero.
    while (mcnt[0] != 16'hFFFF) begin
      drive(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom), 5'($urandom));
    end
    drive(1'b0, 1'b1, 5'd1, 32'hCAFEF00D, 5'd1, 5'd2);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 4 && sbq.size() > 0; w++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
